// File: rtl/alu_share_controller.sv
// Shares one 16-bit EXE-stage ALU between the in-order pipeline and an
// iterative shift-and-add multiplier, with a starvation guard for the multiplier.
module alu_share_controller #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [2:0]  pipe_signals,
  input  logic [15:0] pipe_a,
  input  logic [15:0] pipe_b,
  input  logic [15:0] pipe_imm,
  output logic        pipe_stall,
  output logic [15:0] pipe_result,
  output logic        pipe_result_valid,
  input  logic        mul_start,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  output logic        mul_busy,
  output logic        mul_done,
  output logic [15:0] mul_result,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_acc;
  logic [15:0]      r_mcand;
  logic [15:0]      r_mplier;
  logic [15:0]      r_pipe_result;
  logic [15:0]      r_mul_result;
  logic             r_pipe_result_valid;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_run;
  logic w_mplier_zero;
  logic w_mul_req;
  logic w_starved;
  logic w_mul_grant;
  logic w_pipe_grant;
  logic w_step;
  logic w_last_step;

  assign w_run         = (r_state == S_RUN);
  assign w_mplier_zero = (r_mplier == 16'd0);
  assign w_mul_req     = w_run && !w_mplier_zero && r_mplier[0];
  assign w_starved     = (r_starve_cnt == LIMIT);
  assign w_mul_grant   = w_mul_req && (!pipe_valid || w_starved);
  assign w_pipe_grant  = pipe_valid && !w_mul_grant;

  // A RUN cycle advances one bit unless its set bit is still waiting on the ALU
  assign w_step      = w_run && !w_mplier_zero && (!r_mplier[0] || w_mul_grant);
  assign w_last_step = w_step && (r_mplier[15:1] == 15'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (mul_start) w_state_next = S_RUN;
      S_RUN:  if (w_mplier_zero || w_last_step) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: status flags, arbitration and ALU operand steering
  always_comb begin
    mul_busy   = (r_state != S_IDLE);
    mul_done   = (r_state == S_DONE);
    pipe_stall = pipe_valid && w_mul_grant;
    alu_a      = 16'd0;
    alu_b      = 16'd0;
    alu_op     = 2'b00;
    if (w_mul_grant) begin
      alu_a  = r_acc;
      alu_b  = r_mcand;
      alu_op = 2'b01;
    end else if (w_pipe_grant) begin
      alu_a  = pipe_a;
      alu_b  = pipe_signals[2] ? pipe_imm : pipe_b;
      alu_op = pipe_signals[1:0];
    end
  end

  // Multiplier datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= 16'd0;
      r_mcand      <= 16'd0;
      r_mplier     <= 16'd0;
      r_mul_result <= 16'd0;
    end else begin
      if (r_state == S_IDLE && mul_start) begin
        r_mcand  <= mul_a;
        r_mplier <= mul_b;
        r_acc    <= 16'd0;
      end else if (w_run) begin
        if (w_mplier_zero) begin
          r_mul_result <= r_acc;
        end else if (w_step) begin
          if (w_mul_grant) r_acc <= alu_result;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          // The final add lands in acc on this same edge, so forward it
          if (w_last_step) r_mul_result <= w_mul_grant ? alu_result : r_acc;
        end
      end
    end
  end

  // Starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!w_run || w_mul_grant) begin
      r_starve_cnt <= '0;
    end else if (w_mul_req && pipe_valid && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Pipeline result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_result       <= 16'd0;
      r_pipe_result_valid <= 1'b0;
    end else begin
      r_pipe_result_valid <= w_pipe_grant;
      if (w_pipe_grant) r_pipe_result <= alu_result;
    end
  end

  assign pipe_result       = r_pipe_result;
  assign pipe_result_valid = r_pipe_result_valid;
  assign mul_result        = r_mul_result;

endmodule

// File: tb/tb_alu_share_controller.sv
// Directed-vector bench for alu_share_controller with a behavioural ALU attached.
module tb_alu_share_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [2:0]  pipe_signals;
  logic [15:0] pipe_a, pipe_b, pipe_imm;
  logic        pipe_stall;
  logic [15:0] pipe_result;
  logic        pipe_result_valid;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_busy, mul_done;
  logic [15:0] mul_result;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a + alu_b;
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = 16'd0;
    endcase
  end

  alu_share_controller #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_signals(pipe_signals),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_imm(pipe_imm),
    .pipe_stall(pipe_stall), .pipe_result(pipe_result),
    .pipe_result_valid(pipe_result_valid),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply and checks result, RUN length, stall count and pipeline completions
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic pv, input logic poke, input logic [15:0] exp_res,
                         input int exp_run, input int exp_stall);
    int run_cyc, stall_cyc, pipe_miss;
    logic prev_grant, finished;
    run_cyc = 0; stall_cyc = 0; pipe_miss = 0; prev_grant = 1'b0; finished = 1'b0;
    pipe_valid = pv; pipe_signals = 3'b001; pipe_a = 16'd15; pipe_b = 16'hFFF6;
    mul_a = a; mul_b = b; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int k = 0; k < 200 && !finished; k++) begin
      if (prev_grant && (!pipe_result_valid || pipe_result !== 16'd5)) pipe_miss++;
      mul_start = 1'b0;
      if (mul_done) begin
        finished = 1'b1;
      end else begin
        if (mul_busy) run_cyc++;
        if (pipe_stall) stall_cyc++;
        if (poke && run_cyc == 1) begin
          mul_start = 1'b1; mul_a = 16'd7; mul_b = 16'd7;
        end
        prev_grant = pv && !pipe_stall;
        tick();
      end
    end
    mul_start = 1'b0;
    check({tag, "_finished"}, {31'd0, finished}, 32'd1);
    check({tag, "_result"}, {16'd0, mul_result}, {16'd0, exp_res});
    check({tag, "_run_cycles"}, run_cyc, exp_run);
    check({tag, "_stall_cycles"}, stall_cyc, exp_stall);
    prev_grant = pv && !pipe_stall;
    tick();
    if (prev_grant && (!pipe_result_valid || pipe_result !== 16'd5)) pipe_miss++;
    check({tag, "_busy_after"}, {31'd0, mul_busy}, 32'd0);
    check({tag, "_done_once"}, {31'd0, mul_done}, 32'd0);
    check({tag, "_result_held"}, {16'd0, mul_result}, {16'd0, exp_res});
    check({tag, "_pipe_ops"}, pipe_miss, 0);
    pipe_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [2:0]  sig;
    logic [15:0] exp;
  } pvec_t;

  pvec_t pvecs[5];

  initial begin
    reset = 1'b1; pipe_valid = 1'b0; pipe_signals = 3'b000;
    pipe_a = 16'd0; pipe_b = 16'd0; pipe_imm = 16'd0;
    mul_start = 1'b0; mul_a = 16'd0; mul_b = 16'd0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pipe_result", {16'd0, pipe_result}, 32'd0);
    check("rst_pipe_valid", {31'd0, pipe_result_valid}, 32'd0);
    check("rst_mul_result", {16'd0, mul_result}, 32'd0);
    check("rst_mul_done", {31'd0, mul_done}, 32'd0);
    check("rst_mul_busy", {31'd0, mul_busy}, 32'd0);
    tick();

    pvecs[0] = '{3'b000, 16'd6};
    pvecs[1] = '{3'b001, 16'd5};
    pvecs[2] = '{3'b010, 16'd25};
    pvecs[3] = '{3'b101, 16'd20};
    pvecs[4] = '{3'b110, 16'd10};
    pipe_a = 16'd15; pipe_b = 16'hFFF6; pipe_imm = 16'd5;
    for (int i = 0; i < 5; i++) begin
      pipe_valid = 1'b1; pipe_signals = pvecs[i].sig;
      #1;
      check($sformatf("pipe_stall_%0d", i), {31'd0, pipe_stall}, 32'd0);
      tick();
      check($sformatf("pipe_result_%0d", i), {16'd0, pipe_result}, {16'd0, pvecs[i].exp});
      check($sformatf("pipe_valid_%0d", i), {31'd0, pipe_result_valid}, 32'd1);
    end
    pipe_valid = 1'b0;
    tick();
    check("pipe_valid_idle", {31'd0, pipe_result_valid}, 32'd0);

    run_mul("mul_3x5",     16'd3,     16'd5,   1'b0, 1'b0, 16'd15,    3,  0);
    run_mul("mul_300sq",   16'd300,   16'd300, 1'b0, 1'b0, 16'd24464, 9,  0);
    run_mul("mul_neg2x3",  16'hFFFE,  16'd3,   1'b0, 1'b0, 16'hFFFA,  2,  0);
    run_mul("mul_x0",      16'd1234,  16'd0,   1'b0, 1'b0, 16'd0,     1,  0);
    run_mul("mul_starve",  16'd3,     16'd5,   1'b1, 1'b0, 16'd15,    11, 2);
    run_mul("mul_poke",    16'd3,     16'd5,   1'b0, 1'b1, 16'd15,    3,  0);

    // Abort a multiply with reset while it is running
    mul_a = 16'd300; mul_b = 16'd300; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", {31'd0, mul_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, mul_busy}, 32'd0);
    check("abort_result", {16'd0, mul_result}, 32'd0);
    check("abort_done", {31'd0, mul_done}, 32'd0);
    tick();
    check("abort_done_late", {31'd0, mul_done}, 32'd0);
    check("abort_busy_late", {31'd0, mul_busy}, 32'd0);
    run_mul("mul_after_abort", 16'd3, 16'd5, 1'b0, 1'b0, 16'd15, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
